// File: rtl/ysyx_24070017_exec_ctrl.sv
// Multi-cycle execution sequencer for the RV32 core.
// The sequence is fetch request -> wait for the response -> execute -> optional
// data-memory wait -> commit. The core halts on ebreak and traps on fetch
// errors or timeouts. It also keeps a cycle counter and a retired-instruction
// counter.
module ysyx_24070017_exec_ctrl #(
  parameter int unsigned WORD_LENGTH   = 32,
  parameter logic [31:0] NOP_INST      = 32'h00000013,
  parameter logic [31:0] EBREAK_INST   = 32'h00100073,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [WORD_LENGTH-1:0] pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  input  logic                   imem_resp_err,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  input  logic                   is_mem,
  output logic                   dmem_start,
  input  logic                   dmem_done,
  output logic                   pc_wen,
  output logic                   rf_wen,
  output logic                   halted,
  output logic                   error,
  output logic [31:0]            cycle_cnt,
  output logic [31:0]            instret
);

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_WAIT   = 3'd3,
    HALT       = 3'd4,
    ERR        = 3'd5
  } state_e;

  localparam logic [7:0] TO_LIMIT = 8'(FETCH_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  to_q, to_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;

  logic        req_valid_c;
  logic        inst_valid_c;
  logic        dmem_start_c;
  logic        commit_c;

  // Next-state, latch and counter logic; the strobes are raw and are masked by reset below
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    to_d         = to_q;
    cyc_d        = cyc_q;
    ret_d        = ret_q;
    req_valid_c  = 1'b0;
    inst_valid_c = 1'b0;
    dmem_start_c = 1'b0;
    commit_c     = 1'b0;

    if (state_q != HALT && state_q != ERR) begin
      cyc_d = cyc_q + 32'd1;
    end

    case (state_q)
      FETCH_REQ: begin
        req_valid_c = run;
        if (run && imem_req_ready) begin
          state_d = FETCH_WAIT;
          to_d    = 8'd0;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = ERR;
          end else begin
            inst_d  = imem_resp_data;
            state_d = EXEC;
          end
        end else begin
          to_d = to_q + 8'd1;
          if (to_d == TO_LIMIT) begin
            state_d = ERR;
          end
        end
      end
      EXEC: begin
        inst_valid_c = 1'b1;
        if (inst_q == EBREAK_INST) begin
          state_d = HALT;
        end else if (is_mem) begin
          dmem_start_c = 1'b1;
          state_d      = MEM_WAIT;
        end else begin
          commit_c = 1'b1;
          state_d  = FETCH_REQ;
        end
      end
      MEM_WAIT: begin
        inst_valid_c = 1'b1;
        if (dmem_done) begin
          commit_c = 1'b1;
          state_d  = FETCH_REQ;
        end
      end
      HALT: state_d = HALT;
      ERR:  state_d = ERR;
      default: state_d = FETCH_REQ;
    endcase

    if (commit_c) begin
      ret_d = ret_q + 32'd1;
    end
  end

  // State, instruction latch, timeout and counters; reset returns to a clean fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      inst_q  <= NOP_INST;
      to_q    <= 8'd0;
      cyc_q   <= 32'd0;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  // While reset is asserted every strobe stays low, so a late dmem_done cannot commit
  assign imem_req_valid = req_valid_c & ~rst;
  assign imem_req_addr  = pc;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_c & ~rst;
  assign dmem_start     = dmem_start_c & ~rst;
  assign pc_wen         = commit_c & ~rst;
  assign rf_wen         = commit_c & ~rst;
  assign halted         = (state_q == HALT) & ~rst;
  assign error          = (state_q == ERR) & ~rst;
  assign cycle_cnt      = cyc_q;
  assign instret        = ret_q;

endmodule

// File: tb/tb_ysyx_24070017_exec_ctrl.sv
// Testbench for ysyx_24070017_exec_ctrl.
// The reference model works per instruction. Each transaction is described by
// its fetch, response and memory delays. Expected strobes, cycle counts and
// retired counts follow from those delays with plain arithmetic.
module tb_ysyx_24070017_exec_ctrl;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic [31:0] inst;
  logic        inst_valid;
  logic        is_mem;
  logic        dmem_start;
  logic        dmem_done;
  logic        pc_wen;
  logic        rf_wen;
  logic        halted;
  logic        error;
  logic [31:0] cycle_cnt;
  logic [31:0] instret;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_cyc;
  logic [31:0] exp_ret;
  logic [31:0] exp_inst;

  ysyx_24070017_exec_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .is_mem         (is_mem),
    .dmem_start     (dmem_start),
    .dmem_done      (dmem_done),
    .pc_wen         (pc_wen),
    .rf_wen         (rf_wen),
    .halted         (halted),
    .error          (error),
    .cycle_cnt      (cycle_cnt),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk1({tag, "_pc_wen"}, pc_wen, 1'b0);
    chk1({tag, "_rf_wen"}, rf_wen, 1'b0);
    chk1({tag, "_dmem_start"}, dmem_start, 1'b0);
  endtask

  // Hold reset for one edge with noisy inputs; all strobes must stay low
  task automatic do_reset();
    rst             = 1'b1;
    run             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b0;
    imem_resp_data  = $urandom;
    is_mem          = 1'b0;
    dmem_done       = 1'b1;
    tick();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk_idle("rst");
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk("rst_inst", inst, NOP);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_done       = 1'b0;
    exp_cyc         = 32'd0;
    exp_ret         = 32'd0;
    exp_inst        = NOP;
  endtask

  // One instruction: rdy_dly refused request cycles, resp_dly silent wait
  // cycles, and mem_dly memory-wait cycles before dmem_done.
  task automatic do_instr(input logic [31:0] addr, input logic [31:0] word, input logic mem,
                          input int rdy_dly, input int resp_dly, input int mem_dly);
    bit ebrk;
    ebrk = (word == EBREAK);
    for (int i = 0; i <= rdy_dly; i++) begin
      run             = 1'b1;
      pc              = addr;
      imem_req_ready  = (i == rdy_dly);
      imem_resp_valid = 1'($urandom);
      imem_resp_err   = 1'($urandom);
      imem_resp_data  = $urandom;
      is_mem          = 1'b0;
      dmem_done       = 1'($urandom);
      #1;
      chk1("req_valid", imem_req_valid, 1'b1);
      chk("req_addr", imem_req_addr, addr);
      chk("req_inst_hold", inst, exp_inst);
      chk_idle("req");
      tick();
      exp_cyc++;
    end
    for (int j = 0; j <= resp_dly; j++) begin
      run             = 1'($urandom);
      imem_req_ready  = 1'($urandom);
      imem_resp_valid = (j == resp_dly);
      imem_resp_err   = 1'b0;
      imem_resp_data  = (j == resp_dly) ? word : $urandom;
      dmem_done       = 1'($urandom);
      #1;
      chk1("wait_req_valid", imem_req_valid, 1'b0);
      chk("wait_inst_hold", inst, exp_inst);
      chk_idle("wait");
      tick();
      exp_cyc++;
    end
    exp_inst        = word;
    run             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'($urandom);
    imem_resp_err   = 1'($urandom);
    imem_resp_data  = $urandom;
    is_mem          = mem;
    dmem_done       = 1'($urandom);
    #1;
    chk("exec_inst", inst, word);
    chk1("exec_inst_valid", inst_valid, 1'b1);
    chk1("exec_req_valid", imem_req_valid, 1'b0);
    chk1("exec_dmem_start", dmem_start, mem && !ebrk);
    chk1("exec_pc_wen", pc_wen, !mem && !ebrk);
    chk1("exec_rf_wen", rf_wen, !mem && !ebrk);
    tick();
    exp_cyc++;
    if (!ebrk && !mem) exp_ret++;
    if (mem && !ebrk) begin
      for (int k = 0; k <= mem_dly; k++) begin
        is_mem          = 1'b1;
        dmem_done       = (k == mem_dly);
        imem_resp_valid = 1'($urandom);
        #1;
        chk("mem_inst", inst, word);
        chk1("mem_inst_valid", inst_valid, 1'b1);
        chk1("mem_dmem_start", dmem_start, 1'b0);
        chk1("mem_req_valid", imem_req_valid, 1'b0);
        chk1("mem_pc_wen", pc_wen, k == mem_dly);
        chk1("mem_rf_wen", rf_wen, k == mem_dly);
        tick();
        exp_cyc++;
      end
      exp_ret++;
    end
    is_mem          = 1'b0;
    dmem_done       = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("post_cycle_cnt", cycle_cnt, exp_cyc);
    chk("post_instret", instret, exp_ret);
    chk1("post_halted", halted, ebrk);
    chk1("post_error", error, 1'b0);
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b1;
    run             = 1'b0;
    pc              = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    is_mem          = 1'b0;
    dmem_done       = 1'b0;
    exp_cyc         = 32'd0;
    exp_ret         = 32'd0;
    exp_inst        = NOP;

    // Zero-wait fetch of addi: commit in the third cycle
    do_reset();
    do_instr(32'h80000000, 32'h00500093, 1'b0, 0, 0, 0);
    chk("zw_cycle_cnt", cycle_cnt, 32'd3);
    chk("zw_instret", instret, 32'd1);

    // Five stalled cycles, then the fetch starts in cycle 6
    do_reset();
    for (int s = 0; s < 5; s++) begin
      run            = 1'b0;
      imem_req_ready = 1'b1;
      #1;
      chk1("stall_req_valid", imem_req_valid, 1'b0);
      chk_idle("stall");
      tick();
      exp_cyc++;
    end
    chk("stall_cycle_cnt", cycle_cnt, 32'd5);
    do_instr(32'h80000004, 32'h00100113, 1'b0, 0, 0, 0);
    chk("stall_total_cycles", cycle_cnt, 32'd8);

    // Load whose dmem_done comes four cycles after dmem_start
    do_instr(32'h80000008, 32'h00002083, 1'b1, 0, 0, 3);
    chk("load_instret", instret, 32'd2);

    // Random mix of ALU and memory instructions with random delays
    for (int r = 0; r < 40; r++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == EBREAK) w = NOP;
      do_instr({$urandom_range(0, 32'hFFFF), 2'b00}, w, 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 5));
    end

    // ebreak halts: no commit, no requests, counters frozen
    do_instr(32'h80000100, EBREAK, 1'b1, 1, 1, 0);
    for (int h = 0; h < 6; h++) begin
      run             = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'($urandom);
      dmem_done       = 1'($urandom);
      #1;
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_req_valid", imem_req_valid, 1'b0);
      chk_idle("halt");
      chk("halt_inst", inst, EBREAK);
      chk("halt_cycle_cnt", cycle_cnt, exp_cyc);
      chk("halt_instret", instret, exp_ret);
      tick();
    end

    // A bus error on the fetch response traps
    do_reset();
    run            = 1'b1;
    pc             = 32'h80000200;
    imem_req_ready = 1'b1;
    tick();
    exp_cyc++;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    imem_resp_data  = 32'h00500093;
    tick();
    exp_cyc++;
    imem_resp_err = 1'b0;
    for (int e = 0; e < 4; e++) begin
      imem_resp_valid = 1'($urandom);
      #1;
      chk1("err_error", error, 1'b1);
      chk1("err_halted", halted, 1'b0);
      chk1("err_req_valid", imem_req_valid, 1'b0);
      chk_idle("err");
      chk("err_inst", inst, NOP);
      chk("err_cycle_cnt", cycle_cnt, exp_cyc);
      tick();
    end

    // No response at all: the trap happens after exactly 255 waiting cycles
    do_reset();
    run             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    tick();
    exp_cyc++;
    for (int t = 0; t < 255; t++) begin
      #1;
      if (t == 0 || t == 254) begin
        chk1("to_error_early", error, 1'b0);
        chk1("to_req_valid", imem_req_valid, 1'b0);
      end
      tick();
      exp_cyc++;
    end
    chk1("to_error", error, 1'b1);
    chk("to_cycle_cnt", cycle_cnt, 32'd256);
    tick();
    chk1("to_error_sticky", error, 1'b1);
    chk("to_cycle_frozen", cycle_cnt, 32'd256);
    do_reset();
    #1;
    chk1("to_rst_req_valid", imem_req_valid, 1'b1);
    chk1("to_rst_error", error, 1'b0);

    // Reset in MEM_WAIT while dmem_done arrives: no commit, clean restart
    do_reset();
    run            = 1'b1;
    pc             = 32'h80000300;
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000a103;
    tick();
    imem_resp_valid = 1'b0;
    is_mem          = 1'b1;
    tick();
    dmem_done = 1'b0;
    #1;
    chk1("rm_inst_valid", inst_valid, 1'b1);
    tick();
    rst       = 1'b1;
    dmem_done = 1'b1;
    #1;
    chk1("rm_pc_wen", pc_wen, 1'b0);
    chk1("rm_rf_wen", rf_wen, 1'b0);
    tick();
    rst             = 1'b0;
    dmem_done       = 1'b0;
    is_mem          = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdeadbeef;
    #1;
    chk1("rm_req_valid", imem_req_valid, 1'b1);
    chk("rm_inst", inst, NOP);
    chk("rm_instret", instret, 32'd0);
    chk("rm_cycle_cnt", cycle_cnt, 32'd0);
    exp_cyc  = 32'd0;
    exp_ret  = 32'd0;
    exp_inst = NOP;
    tick();
    exp_cyc++;
    chk("rm_inst_after_spurious", inst, NOP);
    do_instr(32'h80000300, 32'h00300193, 1'b0, 0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
